// File: rtl/lcd_frame_writer_pkg.sv
// rtl/lcd_frame_writer_pkg.sv - shared types, sizes and cell helpers for the frame writer
package lcd_frame_writer_pkg;

    localparam int CELLS = 16;
    localparam int AW    = 4;

    localparam logic [7:0] GRAPH_BLANK = 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SCAN,
        ST_WRITE,
        ST_FINISH
    } state_e;

    // Cell i sits at bits [127-8i -: 8]; {~i, 3'b111} is that top bit without 32-bit math.
    function automatic logic [7:0] cell_byte(input logic [127:0] frame, input logic [AW-1:0] idx);
        return frame[{~idx, 3'b111} -: 8];
    endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// rtl/lcd_frame_writer_if.sv - display RAM write port between the frame writer and the RAM
interface lcd_frame_writer_if;
    import lcd_frame_writer_pkg::*;

    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          ram_we;
    logic          ram_ready;

    modport master (output ram_addr, output ram_data, output ram_we, input ram_ready);
    modport slave  (input ram_addr, input ram_data, input ram_we, output ram_ready);

endinterface

// File: rtl/lcd_frame_writer_cell_diff.sv
// rtl/lcd_frame_writer_cell_diff.sv - selects cell idx of the snapshot and flags whether it must be written
module lcd_frame_writer_cell_diff
    import lcd_frame_writer_pkg::*;
(
    input  logic [127:0]  snap_i,
    input  logic [127:0]  shadow_i,
    input  logic [AW-1:0] idx_i,
    input  logic          full_req_i,
    output logic          need_write_o,
    output logic [7:0]    cell_o
);

    logic [7:0] shadow_byte;

    assign cell_o       = cell_byte(snap_i, idx_i);
    assign shadow_byte  = cell_byte(shadow_i, idx_i);
    assign need_write_o = full_req_i || (cell_o != shadow_byte);

endmodule

// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - writes changed frame cells (or all cells on refresh/reset) into the display RAM
module lcd_frame_writer
    import lcd_frame_writer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [127:0]        frame_in,
    input  logic                refresh,
    lcd_frame_writer_if.master  ram,
    output logic                busy,
    output logic                done
);

    state_e        state_q;
    logic [127:0]  snap_q;
    logic [127:0]  shadow_q;
    logic [127:0]  shadow_d;
    logic          full_req_q;
    logic          pend_q;
    logic [AW-1:0] idx_q;
    logic          ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [7:0]    ram_data_q;
    logic          busy_q;
    logic          done_q;
    logic          need_write;
    logic [7:0]    cell_sel;
    logic          last_cell;
    logic          accept;

    lcd_frame_writer_cell_diff u_cell_diff (
        .snap_i       (snap_q),
        .shadow_i     (shadow_q),
        .idx_i        (idx_q),
        .full_req_i   (full_req_q),
        .need_write_o (need_write),
        .cell_o       (cell_sel)
    );

    assign last_cell = (idx_q == AW'(CELLS - 1));
    assign accept    = (state_q == ST_WRITE) && ram_we_q && ram.ram_ready;

    always_comb begin
        shadow_d = shadow_q;
        if (accept) begin
            shadow_d[{~idx_q, 3'b111} -: 8] = ram_data_q;
        end
    end

    // A refresh arriving once scanning has begun is parked in pend_q so the
    // current pass stays a diff pass and the full rewrite follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            shadow_q   <= '0;
            full_req_q <= 1'b1;
            pend_q     <= 1'b0;
            idx_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= GRAPH_BLANK;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            shadow_q <= shadow_d;
            case (state_q)
                ST_IDLE: begin
                    if (refresh) full_req_q <= 1'b1;
                    if (refresh || full_req_q || (frame_in != shadow_q)) begin
                        state_q <= ST_CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    snap_q  <= frame_in;
                    idx_q   <= '0;
                    if (refresh) full_req_q <= 1'b1;
                    state_q <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (refresh) pend_q <= 1'b1;
                    if (need_write) begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= idx_q;
                        ram_data_q <= cell_sel;
                        state_q    <= ST_WRITE;
                    end else if (last_cell) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                ST_WRITE: begin
                    if (refresh) pend_q <= 1'b1;
                    if (ram.ram_ready) begin
                        ram_we_q <= 1'b0;
                        if (last_cell) begin
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end else begin
                            idx_q   <= idx_q + AW'(1);
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_FINISH: begin
                    full_req_q <= pend_q || refresh;
                    pend_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    ram_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram.ram_we   = ram_we_q;
    assign ram.ram_addr = ram_addr_q;
    assign ram.ram_data = ram_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb/tb_lcd_frame_writer.sv - self-checking bench for lcd_frame_writer against a frame-level model
module tb_lcd_frame_writer;
    import lcd_frame_writer_pkg::*;

    logic         clk;
    logic         rst;
    logic         refresh;
    logic [127:0] frame_in;
    logic         busy;
    logic         done;

    lcd_frame_writer_if ram_if();

    lcd_frame_writer dut (
        .clk      (clk),
        .rst      (rst),
        .frame_in (frame_in),
        .refresh  (refresh),
        .ram      (ram_if),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic         rdy_rand  = 1'b0;
    int           stall_req = 0;
    logic [127:0] model_img;
    logic         model_full;

    logic [11:0]  wq[$];
    logic [7:0]   mem[16];
    int           hold_bad   = 0;
    int           hold_n     = 0;
    logic         prev_stall = 1'b0;
    logic [3:0]   p_addr;
    logic [7:0]   p_data;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [127:0] f, input int i);
        logic [127:0] t;
        t = f >> (8 * (15 - i));
        return t[7:0];
    endfunction

    function automatic logic [127:0] set_byte(input logic [127:0] f, input int i, input logic [7:0] b);
        int s;
        s = 8 * (15 - i);
        return (f & ~(128'hFF << s)) | (128'(b) << s);
    endfunction

    // RAM side: ready pattern, accepted-write log and hold-stability watch
    initial begin
        int stl;
        stl = 0;
        ram_if.ram_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ram_if.ram_we === 1'b1 && stl < stall_req) begin
                ram_if.ram_ready = 1'b0;
                stl++;
            end else begin
                ram_if.ram_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (ram_if.ram_we !== 1'b1) stl = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && prev_stall) begin
            hold_n <= hold_n + 1;
            if (!ram_if.ram_we || ram_if.ram_addr != p_addr || ram_if.ram_data != p_data)
                hold_bad <= hold_bad + 1;
        end
        prev_stall <= !rst && ram_if.ram_we && !ram_if.ram_ready;
        p_addr     <= ram_if.ram_addr;
        p_data     <= ram_if.ram_data;
        if (!rst && ram_if.ram_we && ram_if.ram_ready) begin
            wq.push_back({ram_if.ram_addr, ram_if.ram_data});
            mem[ram_if.ram_addr] <= ram_if.ram_data;
        end
    end

    task automatic at_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        check_eq({nm, "/ram_we"},   ram_if.ram_we,   0);
        check_eq({nm, "/ram_addr"}, ram_if.ram_addr, 0);
        check_eq({nm, "/ram_data"}, ram_if.ram_data, 0);
        check_eq({nm, "/busy"},     busy,            0);
        check_eq({nm, "/done"},     done,            0);
    endtask

    task automatic idle_check(input int n, input string nm);
        bit we_seen, busy_seen;
        we_seen = 0;
        busy_seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (ram_if.ram_we !== 1'b0) we_seen = 1;
            if (busy !== 1'b0) busy_seen = 1;
        end
        check_eq({nm, "/idle_we"},   we_seen,   0);
        check_eq({nm, "/idle_busy"}, busy_seen, 0);
    endtask

    // Cycle k=0 is the IDLE cycle that sees the trigger; refresh pulses in cycle rfsh_at.
    task automatic run_pass(input int k0, input int rfsh_at, input int extra, input string nm);
        int exp_addr[$];
        int sum, exp_total, wbase, hbase, done_k, idle_k, n_done;
        bit seen, fin, full;
        logic [127:0] img;
        logic [11:0] w;

        full = model_full || rfsh_at == 0 || rfsh_at == 1;
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            if (full || byte_at(frame_in, i) != byte_at(model_img, i)) begin
                exp_addr.push_back(i);
                sum += 2;
            end else begin
                sum += 1;
            end
        end
        exp_total = 2 + sum + 1 + extra;
        wbase = wq.size();
        hbase = hold_bad;
        done_k = -1;
        idle_k = -1;
        n_done = 0;
        seen = 0;
        fin = 0;
        for (int k = k0; k < 600; k++) begin
            if (k > 0) at_drive();
            refresh = (k == rfsh_at);
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                done_k = k;
            end
            if (busy === 1'b1) seen = 1;
            else if (seen) begin
                idle_k = k;
                fin = 1;
                break;
            end
        end
        refresh = 1'b0;
        check_eq({nm, "/finished"},  fin,    1);
        check_eq({nm, "/done_once"}, n_done, 1);
        check_eq({nm, "/busy_drop"}, idle_k, done_k + 1);
        if (!rdy_rand) check_eq({nm, "/latency"}, done_k + 1, exp_total);
        check_eq({nm, "/n_writes"}, wq.size() - wbase, exp_addr.size());
        for (int j = 0; j < exp_addr.size() && wbase + j < wq.size(); j++) begin
            w = wq[wbase + j];
            check_eq({nm, "/wr_addr"}, w[11:8], exp_addr[j]);
            check_eq({nm, "/wr_data"}, w[7:0],  byte_at(frame_in, exp_addr[j]));
        end
        img = '0;
        for (int i = 0; i < 16; i++) img = (img << 8) | 128'(mem[i]);
        check_eq({nm, "/ram_img"}, img, frame_in);
        check_eq({nm, "/hold"}, hold_bad - hbase, 0);
        model_img  = frame_in;
        model_full = (rfsh_at >= 2 && rfsh_at <= exp_total - 1);
    endtask

    initial begin
        logic [127:0] nf;
        int hb, wbase, nchg;
        bit hit, do_r;

        rst = 1'b1;
        refresh = 1'b0;
        frame_in = '0;
        foreach (frame_in[i]) if (i < 0) frame_in = '0;
        frame_in = set_byte(frame_in, 5, 8'h41);
        frame_in = set_byte(frame_in, 6, 8'h41);
        frame_in = set_byte(frame_in, 9, 8'h41);
        frame_in = set_byte(frame_in, 10, 8'h41);
        model_img  = '0;
        model_full = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        at_drive();
        rst = 1'b0;
        run_pass(0, -1, 0, "first");

        at_drive();
        idle_check(100, "hold");

        at_drive();
        frame_in = set_byte(frame_in, 6, 8'h42);
        run_pass(0, -1, 0, "cell6");

        stall_req = 5;
        at_drive();
        frame_in = set_byte(frame_in, 0, 8'h33);
        hb = hold_n;
        run_pass(0, -1, 5, "stall");
        check_eq("stall/cycles", hold_n - hb, 5);
        stall_req = 0;

        at_drive();
        run_pass(0, 0, 0, "refresh");

        at_drive();
        frame_in = set_byte(frame_in, 12, 8'h5A);
        run_pass(0, 10, 0, "mid_rfsh");
        run_pass(1, -1, 0, "after_rfsh");

        at_drive();
        refresh = 1'b1;
        wbase = wq.size();
        hit = 0;
        for (int c = 0; c < 200; c++) begin
            at_drive();
            refresh = 1'b0;
            if (ram_if.ram_we === 1'b1 && wq.size() - wbase == 7) begin
                hit = 1;
                break;
            end
        end
        check_eq("rst8/reached", hit, 1);
        rst = 1'b1;
        at_drive();
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst8");
        check_eq("rst8/abandoned", wq.size() - wbase, 7);
        model_full = 1'b1;
        run_pass(1, -1, 0, "post_rst");

        rdy_rand = 1'b1;
        for (int it = 0; it < 24; it++) begin
            at_drive();
            nf = model_img;
            nchg = $urandom_range(0, 3);
            for (int c = 0; c < nchg; c++)
                nf = set_byte(nf, $urandom_range(0, 15), 8'($urandom));
            do_r = ($urandom_range(0, 4) == 0);
            frame_in = nf;
            if (nf == model_img && !do_r && !model_full) idle_check(6, "rand_idle");
            else run_pass(0, do_r ? 0 : -1, 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

Consumer side of the 128-bit game frame bus: game modules drive `data_output` (16 graph codes, 4×4 cells) toward the RAM controller, and this block is that controller's write engine. It snapshots the frame and writes its bytes one per handshake into the 16-entry display RAM. Only cells that differ from what was last written are sent, except after reset or a refresh request, when all 16 are written.

## Interface
Parameters:
- `CELLS`, 16: number of byte cells in a frame. Fixed by the 128-bit bus.
- `AW`, 4: display RAM address width. Must satisfy `2**AW == CELLS`.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `frame_in` in 128: frame from the selected game module. `frame_in[127:120]` is cell 0 (row 0, col 0). `frame_in[7:0]` is cell 15.
- `refresh` in 1: single-cycle pulse that forces a full 16-cell rewrite.
- `ram_addr` out AW: cell address. `addr = row*4 + col`.
- `ram_data` out 8: graph code for `ram_addr`.
- `ram_we` out 1: write request.
- `ram_ready` in 1: RAM accepts a write.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when a frame update completes.

## Operation
- Internal registers:
  - `snap` (128): captured frame.
  - `shadow` (128): contents of the display RAM as last written.
  - `full_req` (1): full rewrite pending.
  - `idx` (AW): current cell index.
- States and transitions:
  - IDLE → CAPTURE when `frame_in != shadow`, or `full_req`, or `refresh`.
  - CAPTURE: load `snap <= frame_in` and `idx <= 0`. If `refresh` is seen here, set `full_req`. Go to SCAN.
  - SCAN: test cell `idx`.
    - Write needed (`full_req` or `snap` byte ≠ `shadow` byte): go to WRITE.
    - Not needed and `idx == 15`: go to FINISH.
    - Otherwise: `idx <= idx + 1`, stay in SCAN.
  - WRITE: hold `ram_we = 1`, `ram_addr = idx`, `ram_data = snap` byte `idx`.
    - On the accepting cycle (`ram_we && ram_ready`), update that `shadow` byte.
    - If `idx == 15`: go to FINISH. Otherwise `idx <= idx + 1` and go to SCAN.
  - FINISH: `done = 1`, clear `full_req`, go to IDLE.
- `ram_addr` and `ram_data` stay stable while `ram_we` is high and `ram_ready` is low. `ram_we` never drops before acceptance.
- `frame_in` changes after CAPTURE are ignored for the current pass. They are picked up by the next IDLE comparison.
- A `refresh` pulse during any non-IDLE state sets `full_req`. The full rewrite then happens on the following pass.
- `idx` wraps 15 → 0 only through CAPTURE. It never increments past 15.

## Timing
- Reset values:
  - `ram_we = 0`, `ram_addr = 0`, `ram_data = 0`, `busy = 0`, `done = 0`.
  - `snap = 0`, `shadow = 0`, `idx = 0`.
  - `full_req = 1`: the first pass after reset writes all 16 cells.
  - State IDLE.
- `rst` overrides everything in the same edge, including mid-write. An interrupted write is abandoned and `full_req` is set again.
- Latency, trigger seen in IDLE at cycle 0:
  - Cycle 1: CAPTURE.
  - Cycle 2: first SCAN.
  - First `ram_we` at cycle 3 at the earliest.
- Each skipped cell costs 1 cycle. Each written cell costs 1 SCAN cycle plus WRITE cycles until accepted (1 if `ram_ready` is tied high).
- Full write with `ram_ready = 1`: 2 + 16×2 + 1 = 35 cycles from trigger to `done`. `busy` drops the cycle after `done`.
- No-change frame: IDLE is held, `busy = 0`, no writes issued.
- Outputs are registered. `done` pulses exactly once per pass.

## Structure
- Shared package:
  - State encoding (IDLE, CAPTURE, SCAN, WRITE, FINISH).
  - `CELLS` and `AW`.
  - Byte-select function: cell `i` is bits `[127-8i -: 8]`.
  - `GRAPH_BLANK = 8'd0`, shared with the game modules.
- One natural sub-module, `cell_diff`: combinational, taking `snap`, `shadow`, `idx` and `full_req`, and producing `need_write` and the selected byte. The FSM and registers stay in the top module.

## Test plan
- Reset, then `frame_in` with cells 5, 6, 9, 10 = `8'h41` and all other cells 0, `ram_ready = 1`:
  - 16 writes in address order 0..15.
  - `done` pulses 35 cycles after the trigger.
  - RAM model matches `frame_in`.
- Same frame held after that pass: no `ram_we` for 100 cycles, `busy` stays 0.
- Only cell 6 changed to `8'h42`:
  - Exactly one write, `addr = 6`, `data = 8'h42`.
  - `done` 2 + 6 + 2 + 9 + 1 = 20 cycles after the trigger.
- `ram_ready` low for 5 cycles on the write to `addr = 0`:
  - `ram_we`, `ram_addr` and `ram_data` held constant throughout.
  - Exactly one accepted write.
- `refresh` pulse with an unchanged frame: a full 16-cell rewrite. A `refresh` pulse during an active pass gives a second full pass immediately after `done`.
- `rst` asserted at the 8th write:
  - Outputs are at their reset values the next cycle.
  - The next pass writes all 16 cells.
